// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : icache_pkg                                                        |
// | Desc   : Shared constants and FSM encodings for the instruction cache.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package icache_pkg;

  localparam int c_INST_W = 32;
  localparam int c_ADDR_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_IDLE  = 2'd0;
  localparam state_t c_ST_ISSUE = 2'd1;
  localparam state_t c_ST_WAIT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : icache_array                                                      |
// | Desc   : Direct-mapped valid/tag/data storage, combinational hit lookup    |
// |          and a single refill write port.                                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [TAG_W-1:0]      i_rd_tag,
  output logic                  o_hit,
  output logic [c_INST_W-1:0]   o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [c_INST_W-1:0]   i_wr_data
);

  localparam int c_LINES = 1 << INDEX_BITS;

  logic [c_LINES-1:0]  r_valid;
  logic [TAG_W-1:0]    r_tag  [c_LINES];
  logic [c_INST_W-1:0] r_data [c_LINES];

  // Valid bits are the only storage cleared by reset; a refill marks its line valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data are plain storage; a refill overwrites the line regardless of its old owner.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : icache                                                            |
// | Desc   : Direct-mapped instruction cache. Hits answer next cycle; misses   |
// |          run one word fetch through the memory controller handshake.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = c_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_pc,
  input  logic                flush,
  output logic                if_valid,
  output logic [c_INST_W-1:0] if_inst,
  output logic                if_busy,
  output logic [ADDR_W-1:0]   mc_addr,
  output logic                mc_flag,
  input  logic [c_INST_W-1:0] mc_val,
  input  logic                mc_isok
);

  localparam int c_TAG_W = ADDR_W - INDEX_BITS - 2;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_flushed;
  logic                r_if_valid;
  logic [c_INST_W-1:0] r_if_inst;
  logic                r_if_busy;
  logic                r_mc_flag;
  logic [ADDR_W-1:0]   r_mc_addr;

  logic                w_flushed_nxt;
  logic                w_valid_nxt;
  logic [c_INST_W-1:0] w_inst_nxt;
  logic                w_busy_nxt;
  logic                w_flag_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_refill;
  logic                w_hit;
  logic [c_INST_W-1:0] w_rd_data;
  logic [ADDR_W-1:0]   w_pc_word;

  // Byte-offset bits are dropped by masking so the whole pc feeds one word address.
  assign w_pc_word = if_pc & ~ADDR_W'(3);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (c_TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_pc_word[INDEX_BITS+1:2]),
    .i_rd_tag   (w_pc_word[ADDR_W-1:INDEX_BITS+2]),
    .o_hit      (w_hit),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_refill && rdy),
    .i_wr_index (r_mc_addr[INDEX_BITS+1:2]),
    .i_wr_tag   (r_mc_addr[ADDR_W-1:INDEX_BITS+2]),
    .i_wr_data  (mc_val)
  );

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_ST_IDLE;
      r_flushed  <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      r_if_busy  <= 1'b0;
      r_mc_flag  <= 1'b0;
      r_mc_addr  <= '0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_flushed  <= w_flushed_nxt;
      r_if_valid <= w_valid_nxt;
      r_if_inst  <= w_inst_nxt;
      r_if_busy  <= w_busy_nxt;
      r_mc_flag  <= w_flag_nxt;
      r_mc_addr  <= w_addr_nxt;
    end
  end

  // Next state: ISSUE is a single dead cycle so a stale isok from the last fetch is skipped.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (!flush && if_req && !w_hit) w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
      c_ST_WAIT:  if (mc_isok) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output/datapath next values; a flushed miss still refills but produces no response.
  always_comb begin
    w_valid_nxt   = 1'b0;
    w_inst_nxt    = r_if_inst;
    w_busy_nxt    = r_if_busy;
    w_flag_nxt    = r_mc_flag;
    w_addr_nxt    = r_mc_addr;
    w_flushed_nxt = r_flushed;
    w_refill      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (!flush && if_req) begin
          if (w_hit) begin
            w_valid_nxt = 1'b1;
            w_inst_nxt  = w_rd_data;
          end else begin
            w_flag_nxt    = 1'b1;
            w_busy_nxt    = 1'b1;
            w_addr_nxt    = w_pc_word;
            w_flushed_nxt = 1'b0;
          end
        end
      end
      c_ST_ISSUE: begin
        if (flush) w_flushed_nxt = 1'b1;
      end
      c_ST_WAIT: begin
        if (mc_isok) begin
          w_refill      = 1'b1;
          w_flag_nxt    = 1'b0;
          w_busy_nxt    = 1'b0;
          w_flushed_nxt = 1'b0;
          if (!(r_flushed || flush)) begin
            w_valid_nxt = 1'b1;
            w_inst_nxt  = mc_val;
          end
        end else if (flush) begin
          w_flushed_nxt = 1'b1;
        end
      end
      default: begin
        w_flag_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign if_valid = r_if_valid;
  assign if_inst  = r_if_inst;
  assign if_busy  = r_if_busy;
  assign mc_flag  = r_mc_flag;
  assign mc_addr  = r_mc_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_icache                                                         |
// | Desc   : Directed self-checking bench for the instruction cache.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_pc;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_busy;
  logic [31:0] mc_addr;
  logic        mc_flag;
  logic [31:0] mc_val;
  logic        mc_isok;

  int n_checks;
  int n_errors;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        fl;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic        exp_flag;
  } vec_t;

  vec_t vecs[5];

  icache #(
    .INDEX_BITS (6),
    .ADDR_W     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .if_req   (if_req),
    .if_pc    (if_pc),
    .flush    (flush),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_busy  (if_busy),
    .mc_addr  (mc_addr),
    .mc_flag  (mc_flag),
    .mc_val   (mc_val),
    .mc_isok  (mc_isok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full miss: request, ISSUE, one idle WAIT cycle, then isok with the given word.
  task automatic do_miss(input logic [31:0] pc, input logic [31:0] val);
    if_req = 1'b1; if_pc = pc;
    step();
    chk("miss_flag", 32'(mc_flag), 32'd1);
    chk("miss_addr", mc_addr, {pc[31:2], 2'b00});
    chk("miss_busy", 32'(if_busy), 32'd1);
    step();
    chk("issue_flag", 32'(mc_flag), 32'd1);
    step();
    chk("wait_flag", 32'(mc_flag), 32'd1);
    mc_isok = 1'b1; mc_val = val;
    step();
    chk("fill_valid", 32'(if_valid), 32'd1);
    chk("fill_inst", if_inst, val);
    chk("fill_flag", 32'(mc_flag), 32'd0);
    mc_isok = 1'b0; if_req = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_pc = '0; flush = 1'b0;
    mc_val = '0; mc_isok = 1'b0;

    vecs[0] = '{req: 1'b1, pc: 32'h1004, fl: 1'b0, exp_valid: 1'b1, exp_inst: 32'h0051_0113, exp_flag: 1'b0};
    vecs[1] = '{req: 1'b1, pc: 32'h1004, fl: 1'b0, exp_valid: 1'b1, exp_inst: 32'h0051_0113, exp_flag: 1'b0};
    vecs[2] = '{req: 1'b0, pc: 32'h1004, fl: 1'b0, exp_valid: 1'b0, exp_inst: 32'h0,         exp_flag: 1'b0};
    vecs[3] = '{req: 1'b1, pc: 32'h1004, fl: 1'b1, exp_valid: 1'b0, exp_inst: 32'h0,         exp_flag: 1'b0};
    vecs[4] = '{req: 1'b1, pc: 32'h1006, fl: 1'b0, exp_valid: 1'b1, exp_inst: 32'h0051_0113, exp_flag: 1'b0};

    // Reset state
    #1;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_busy", 32'(if_busy), 32'd0);
    chk("rst_flag", 32'(mc_flag), 32'd0);
    chk("rst_addr", mc_addr, 32'd0);
    step();
    rst = 1'b1;
    step();

    // 1. Cold miss with 5 idle cycles before isok
    if_req = 1'b1; if_pc = 32'h0000_1004;
    step();
    chk("cold_flag", 32'(mc_flag), 32'd1);
    chk("cold_addr", mc_addr, 32'h1004);
    chk("cold_busy", 32'(if_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cold_hold_flag", 32'(mc_flag), 32'd1);
      chk("cold_hold_addr", mc_addr, 32'h1004);
      chk("cold_hold_valid", 32'(if_valid), 32'd0);
    end
    mc_isok = 1'b1; mc_val = 32'h0051_0113;
    step();
    chk("cold_valid", 32'(if_valid), 32'd1);
    chk("cold_inst", if_inst, 32'h0051_0113);
    chk("cold_busy_clr", 32'(if_busy), 32'd0);
    chk("cold_flag_clr", 32'(mc_flag), 32'd0);
    mc_isok = 1'b0; if_req = 1'b0;

    // 2. Hits after fill, from the vector table
    for (int i = 0; i < 5; i++) begin
      if_req = vecs[i].req; if_pc = vecs[i].pc; flush = vecs[i].fl;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_flag", i), 32'(mc_flag), 32'(vecs[i].exp_flag));
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_inst", i), if_inst, vecs[i].exp_inst);
    end
    if_req = 1'b0; flush = 1'b0;
    step();

    // 3. Stale isok held high: ISSUE must ignore it
    mc_isok = 1'b1; mc_val = 32'h1111_1111;
    if_req = 1'b1; if_pc = 32'h2000;
    step();
    chk("stale_flag", 32'(mc_flag), 32'd1);
    step();
    chk("stale_issue_flag", 32'(mc_flag), 32'd1);
    chk("stale_issue_valid", 32'(if_valid), 32'd0);
    chk("stale_issue_busy", 32'(if_busy), 32'd1);
    step();
    chk("stale_fill_valid", 32'(if_valid), 32'd1);
    chk("stale_fill_inst", if_inst, 32'h1111_1111);
    chk("stale_fill_flag", 32'(mc_flag), 32'd0);
    mc_isok = 1'b0; if_req = 1'b0;
    step();

    // 4. Index conflict between 0x0 and 0x100
    do_miss(32'h0000_0000, 32'hAAAA_0000);
    do_miss(32'h0000_0100, 32'hBBBB_0100);
    do_miss(32'h0000_0000, 32'hAAAA_0001);

    // 5. Flush during WAIT: refill silently, later hit
    if_req = 1'b1; if_pc = 32'h3008;
    step();
    chk("fl_flag", 32'(mc_flag), 32'd1);
    if_req = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; mc_isok = 1'b1; mc_val = 32'hDEAD_BEEF;
    step();
    chk("fl_no_valid", 32'(if_valid), 32'd0);
    chk("fl_flag_clr", 32'(mc_flag), 32'd0);
    chk("fl_busy_clr", 32'(if_busy), 32'd0);
    mc_isok = 1'b0;
    if_req = 1'b1; if_pc = 32'h3008;
    step();
    chk("fl_hit_valid", 32'(if_valid), 32'd1);
    chk("fl_hit_inst", if_inst, 32'hDEAD_BEEF);
    chk("fl_hit_flag", 32'(mc_flag), 32'd0);
    if_req = 1'b0;
    step();

    // 6a. rdy low for 3 cycles in WAIT with isok asserted
    if_req = 1'b1; if_pc = 32'h4000;
    step();
    if_req = 1'b0;
    step();
    step();
    rdy = 1'b0; mc_isok = 1'b1; mc_val = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_flag", 32'(mc_flag), 32'd1);
      chk("frz_busy", 32'(if_busy), 32'd1);
      chk("frz_valid", 32'(if_valid), 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("frz_fill_valid", 32'(if_valid), 32'd1);
    chk("frz_fill_inst", if_inst, 32'h1234_5678);
    chk("frz_fill_flag", 32'(mc_flag), 32'd0);
    mc_isok = 1'b0;

    // 6b. Async reset in the middle of WAIT
    if_req = 1'b1; if_pc = 32'h5000;
    step();
    if_req = 1'b0;
    step();
    step();
    chk("arst_pre_flag", 32'(mc_flag), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_flag", 32'(mc_flag), 32'd0);
    chk("arst_busy", 32'(if_busy), 32'd0);
    chk("arst_addr", mc_addr, 32'd0);
    step();
    rst = 1'b1;
    if_req = 1'b1; if_pc = 32'h1004;
    step();
    chk("arst_inval_flag", 32'(mc_flag), 32'd1);
    chk("arst_inval_valid", 32'(if_valid), 32'd0);
    if_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
